// File: rtl/trace_scanner.sv
// Snapshots two trace bitmaps on start and streams them out in raster order over a valid/ready pixel port.
// Optional per-player set-pixel counters are enabled with `define TRACE_SCANNER_COUNT_EN.
module trace_scanner #(
  parameter int ROWS = 150,
  parameter int COLS = 200
) (
  input  logic                       clock,
  input  logic                       reset_L,
  input  logic [ROWS-1:0][COLS-1:0]  p1_trace,
  input  logic [ROWS-1:0][COLS-1:0]  p2_trace,
  input  logic                       start,
  output logic                       busy,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [7:0]                 pix_row,
  output logic [7:0]                 pix_col,
  output logic [1:0]                 pix_code,
  output logic                       pix_last,
  output logic                       done
`ifdef TRACE_SCANNER_COUNT_EN
  ,
  output logic [15:0]                p1_count,
  output logic [15:0]                p2_count
`endif
);

  // Handshake: a beat transfers on a rising edge with pix_valid && pix_ready;
  // while pix_valid is high and pix_ready low, row/col/code/last hold steady.

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [7:0] LAST_ROW = 8'(ROWS - 1);
  localparam logic [7:0] LAST_COL = 8'(COLS - 1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [7:0]                r_row;
  logic [7:0]                r_col;
  logic                      r_done;
  logic [ROWS-1:0][COLS-1:0] r_p1_snap;
  logic [ROWS-1:0][COLS-1:0] r_p2_snap;

  logic                      w_busy;
  logic                      w_valid;
  logic [1:0]                w_code;
  logic                      w_last;
  logic                      w_at_end;
  logic                      w_xfer;
  logic                      w_start_acc;

  assign w_at_end    = (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign w_xfer      = w_valid && pix_ready;
  assign w_start_acc = (r_state == IDLE) && start;

  // State register
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = SCAN;
      SCAN: if (w_xfer && w_at_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs derive from registered state only, so reset clears them without a clock.
  always_comb begin
    w_busy  = (r_state == SCAN);
    w_valid = (r_state == SCAN);
    w_code  = 2'b00;
    w_last  = 1'b0;
    if (r_state == SCAN) begin
      w_code = {r_p2_snap[r_row][r_col], r_p1_snap[r_row][r_col]};
      w_last = w_at_end;
    end
  end

  // Raster position and the one-cycle completion pulse
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_row  <= 8'd0;
      r_col  <= 8'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_xfer && w_at_end;
      if (w_start_acc) begin
        r_row <= 8'd0;
        r_col <= 8'd0;
      end else if (w_xfer) begin
        if (r_col == LAST_COL) begin
          r_col <= 8'd0;
          r_row <= (r_row == LAST_ROW) ? 8'd0 : r_row + 8'd1;
        end else begin
          r_col <= r_col + 8'd1;
        end
      end
    end
  end

  // Frame snapshot; contents are irrelevant until the next accepted start.
  always_ff @(posedge clock) begin
    if (w_start_acc) begin
      r_p1_snap <= p1_trace;
      r_p2_snap <= p2_trace;
    end
  end

`ifdef TRACE_SCANNER_COUNT_EN
  logic [15:0] r_p1_cnt;
  logic [15:0] r_p2_cnt;

  // Counters stop moving once the frame ends, so they hold from done to the next start.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      r_p1_cnt <= 16'd0;
      r_p2_cnt <= 16'd0;
    end else if (w_start_acc) begin
      r_p1_cnt <= 16'd0;
      r_p2_cnt <= 16'd0;
    end else if (w_xfer) begin
      r_p1_cnt <= r_p1_cnt + {15'd0, w_code[0]};
      r_p2_cnt <= r_p2_cnt + {15'd0, w_code[1]};
    end
  end

  assign p1_count = r_p1_cnt;
  assign p2_count = r_p2_cnt;
`endif

  assign busy      = w_busy;
  assign pix_valid = w_valid;
  assign pix_row   = r_row;
  assign pix_col   = r_col;
  assign pix_code  = w_code;
  assign pix_last  = w_last;
  assign done      = r_done;

endmodule
